// File: rtl/program_sequencer_pkg.sv
// Shared ISA definitions for the NN processor core.
//  - OP_* : 4-bit opcodes (the top nibble of each instruction word)
//  - seqState_t : instruction sequencer state encoding
//  - is_defined_op() : true for every opcode the core implements
//  - satInc16() : saturating 16-bit increment for the instruction counter
package program_sequencer_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_MUL  = 4'h2;
   localparam logic [3:0] OP_SINN = 4'h3;
   localparam logic [3:0] OP_MAC  = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hB;
   localparam logic [3:0] OP_LD   = 4'hE;
   localparam logic [3:0] OP_ST   = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_MEM,
      ST_MAC_HOLD,
      ST_HALTED,
      ST_ERROR
   } seqState_t;

   function automatic logic is_defined_op(input logic [3:0] op);
      case (op)
         OP_NOP, OP_ADD, OP_MUL, OP_SINN, OP_MAC,
         OP_ADDI, OP_HALT, OP_LD, OP_ST: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

   function automatic logic [15:0] satInc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Bus bundle between the program sequencer, instruction memory and decode.
//  imem_req/imem_addr  -> imem      fetch request and address
//  imem_ack/imem_data  <- imem      fetch completion and fetched word
//  instr_valid/instr   -> decode    instruction presented for issue
//  instr_ready         <- decode    decode accepts the instruction
//  dmem_done           <- datapath  LD/ST data-memory access finished
// master = sequencer side, slave = memory/decode side.
interface program_sequencer_if #(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16
);
   logic                   imem_req;
   logic [PC_WIDTH-1:0]    imem_addr;
   logic                   imem_ack;
   logic [INSTR_WIDTH-1:0] imem_data;
   logic                   instr_valid;
   logic [INSTR_WIDTH-1:0] instr;
   logic                   instr_ready;
   logic                   dmem_done;

   modport master (
      output imem_req, imem_addr, instr_valid, instr,
      input  imem_ack, imem_data, instr_ready, dmem_done
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr,
      output imem_ack, imem_data, instr_ready, dmem_done
   );
endinterface

// File: rtl/program_sequencer_classify.sv
// seq_op_classify: combinational opcode classifier for the sequencer.
//  opcode  in   4   instruction opcode nibble
//  isHalt  out  1   HALT
//  isUndef out  1   opcode outside the defined ISA set
//  isMem   out  1   LD or ST (waits for data-memory completion)
//  isMac   out  1   MAC (multi-cycle occupancy)
module seq_op_classify
   import program_sequencer_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       isHalt,
   output logic       isUndef,
   output logic       isMem,
   output logic       isMac
);
   assign isHalt  = (opcode == OP_HALT);
   assign isUndef = !is_defined_op(opcode);
   assign isMem   = (opcode == OP_LD) || (opcode == OP_ST);
   assign isMac   = (opcode == OP_MAC);
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: instruction fetch/issue sequencer for the NN core.
// Owns the PC, fetches words over the imem req/ack handshake, presents them
// to decode over valid/ready, stalls for LD/ST completion and MAC occupancy,
// stops on HALT and traps on undefined opcodes. All outputs are registered.
//  clk, reset_n   clock, asynchronous active-low reset
//  start          begin/restart; only honoured in IDLE, HALTED, ERROR
//  bus            imem fetch, decode issue and dmem_done (master side)
//  pc             current PC (also drives imem_addr)
//  instr_count    instructions issued since start, saturating
//  halted, error  sticky HALT-retired / undefined-opcode flags
module program_sequencer
   import program_sequencer_pkg::*;
#(
   parameter int PC_WIDTH    = 8,
   parameter int INSTR_WIDTH = 16,
   parameter int START_PC    = 0,
   parameter int MAC_CYCLES  = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   program_sequencer_if.master bus,
   output logic [PC_WIDTH-1:0] pc,
   output logic [15:0]         instr_count,
   output logic                halted,
   output logic                error
);
   localparam logic [PC_WIDTH-1:0] START_ADDR = PC_WIDTH'(START_PC);
   localparam int                  CNT_W      = (MAC_CYCLES > 1) ? $clog2(MAC_CYCLES) : 1;
   localparam logic [CNT_W-1:0]    MAC_LOAD   = CNT_W'(MAC_CYCLES - 1);
   localparam bit                  MAC_MULTI  = (MAC_CYCLES > 1);

   seqState_t              state, stateNext;
   logic [PC_WIDTH-1:0]    pcNext;
   logic [INSTR_WIDTH-1:0] instrReg, instrNext;
   logic                   validReg, validNext;
   logic                   reqReg, reqNext;
   logic [15:0]            countNext;
   logic                   haltNext, errNext;
   logic [CNT_W-1:0]       macCnt, macCntNext;
   logic [3:0]             curOp;
   logic                   isHalt, isUndef, isMem, isMac;

   // In FETCH the incoming word is classified; otherwise the held instruction.
   assign curOp = (state == ST_FETCH) ? bus.imem_data[INSTR_WIDTH-1 -: 4]
                                      : instrReg[INSTR_WIDTH-1 -: 4];

   seq_op_classify uClassify (
      .opcode  (curOp),
      .isHalt  (isHalt),
      .isUndef (isUndef),
      .isMem   (isMem),
      .isMac   (isMac)
   );

   assign bus.imem_req    = reqReg;
   assign bus.imem_addr   = pc;
   assign bus.instr_valid = validReg;
   assign bus.instr       = instrReg;

   always_comb begin
      stateNext  = state;
      pcNext     = pc;
      instrNext  = instrReg;
      validNext  = validReg;
      reqNext    = reqReg;
      countNext  = instr_count;
      haltNext   = halted;
      errNext    = error;
      macCntNext = macCnt;
      case (state)
         ST_IDLE: begin
            if (start) begin
               stateNext = ST_FETCH;
               reqNext   = 1'b1;
            end
         end
         ST_FETCH: begin
            if (reqReg && bus.imem_ack) begin
               instrNext = bus.imem_data;
               reqNext   = 1'b0;
               if (isHalt) begin
                  stateNext = ST_HALTED;
                  haltNext  = 1'b1;
               end else if (isUndef) begin
                  stateNext = ST_ERROR;
                  errNext   = 1'b1;
               end else begin
                  stateNext = ST_ISSUE;
                  validNext = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            if (bus.instr_ready) begin
               validNext = 1'b0;
               pcNext    = pc + 1'b1;
               countNext = satInc16(instr_count);
               if (isMem) begin
                  stateNext = ST_WAIT_MEM;
               end else if (isMac && MAC_MULTI) begin
                  stateNext  = ST_MAC_HOLD;
                  macCntNext = MAC_LOAD;
               end else begin
                  stateNext = ST_FETCH;
                  reqNext   = 1'b1;
               end
            end
         end
         ST_WAIT_MEM: begin
            if (bus.dmem_done) begin
               stateNext = ST_FETCH;
               reqNext   = 1'b1;
            end
         end
         ST_MAC_HOLD: begin
            // Leave as the counter reaches 0 so the next fetch request
            // appears MAC_CYCLES cycles after the MAC was accepted.
            macCntNext = macCnt - 1'b1;
            if (macCntNext == '0) begin
               stateNext = ST_FETCH;
               reqNext   = 1'b1;
            end
         end
         ST_HALTED, ST_ERROR: begin
            if (start) begin
               pcNext    = START_ADDR;
               countNext = '0;
               haltNext  = 1'b0;
               errNext   = 1'b0;
               stateNext = ST_FETCH;
               reqNext   = 1'b1;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         pc          <= START_ADDR;
         instrReg    <= '0;
         validReg    <= 1'b0;
         reqReg      <= 1'b0;
         instr_count <= '0;
         halted      <= 1'b0;
         error       <= 1'b0;
         macCnt      <= '0;
      end else begin
         state       <= stateNext;
         pc          <= pcNext;
         instrReg    <= instrNext;
         validReg    <= validNext;
         reqReg      <= reqNext;
         instr_count <= countNext;
         halted      <= haltNext;
         error       <= errNext;
         macCnt      <= macCntNext;
      end
   end
endmodule

// File: tb/tb_program_sequencer.sv
// Testbench for program_sequencer: directed programs plus a randomized phase,
// with a transaction-level reference model compared against the DUT every cycle.
module tb_program_sequencer;
   localparam int PCW  = 4;
   localparam int IW   = 16;
   localparam int SPC  = 2;
   localparam int MACC = 3;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           start = 1'b0;
   logic [PCW-1:0] pc;
   logic [15:0]    instr_count;
   logic           halted, error;

   program_sequencer_if #(.PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus();

   program_sequencer #(
      .PC_WIDTH(PCW), .INSTR_WIDTH(IW), .START_PC(SPC), .MAC_CYCLES(MACC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
      .pc(pc), .instr_count(instr_count), .halted(halted), .error(error)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // stimulus configuration
   logic [15:0] mem [16];
   bit ackRand = 0, rdyRand = 0, ackNoise = 0, ackHold = 0;
   bit randStart = 0, dmemManual = 0, startPulse = 0, checkEn = 0;
   int ackDelay = 1, ackMax = 0, rdyDelay = 0, rdyMax = 0;

   // observations
   int issues = 0;
   int lastHs = -100;
   int lastReqRise = -100;

   // reference model state
   logic           mReq, mValid, mHalted, mErr, mWait;
   logic [PCW-1:0] mPc;
   logic [15:0]    mCount, mInstr;
   int             mHold;
   logic [15:0]    defMask = 16'hCA1F;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic pulseStart;
      @(posedge clk);
      startPulse = 1'b1;
      @(posedge clk);
      startPulse = 1'b0;
      @(negedge clk);
   endtask

   task automatic waitDone(input int budget, input string name);
      int n;
      n = 0;
      while (!(halted || error) && n < budget) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!(halted || error)) begin
         fails++;
         $display("FAIL %s timeout: halted=%0b error=%0b, expected a stop within %0d cycles",
                  name, halted, error, budget);
      end
   endtask

   task automatic randomizeMem;
      logic [3:0] defOps [8];
      logic [3:0] undefOps [7];
      logic [3:0] op;
      int r;
      defOps   = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h9, 4'hE, 4'hF};
      undefOps = '{4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hC, 4'hD};
      for (int i = 0; i < 16; i++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0)      op = undefOps[$urandom_range(0, 6)];
         else if (r == 1) op = 4'hB;
         else             op = defOps[$urandom_range(0, 7)];
         mem[i] = {op, 12'($urandom)};
      end
   endtask

   // Input driver: memory responder, decode ready, dmem_done and start.
   initial begin
      bit reqSeen, vSeen;
      int reqAge, vAge, curAck, curRdy;
      reqSeen = 0; vSeen = 0; reqAge = 0; vAge = 0; curAck = 0; curRdy = 0;
      bus.imem_ack = 1'b0; bus.imem_data = '0; bus.instr_ready = 1'b0; bus.dmem_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.imem_req) begin
            if (!reqSeen) begin
               reqSeen = 1; reqAge = 0;
               curAck = ackRand ? int'($urandom_range(0, ackMax)) : ackDelay;
            end else reqAge++;
            bus.imem_ack = !ackHold && (reqAge >= curAck);
         end else begin
            reqSeen = 0;
            bus.imem_ack = ackNoise && ($urandom_range(0, 3) == 0);
         end
         bus.imem_data = bus.imem_ack ? mem[bus.imem_addr] : 16'($urandom);
         if (bus.instr_valid) begin
            if (!vSeen) begin
               vSeen = 1; vAge = 0;
               curRdy = rdyRand ? int'($urandom_range(0, rdyMax)) : rdyDelay;
            end else vAge++;
            bus.instr_ready = (vAge >= curRdy);
         end else begin
            vSeen = 0;
            bus.instr_ready = ($urandom_range(0, 1) == 1);
         end
         if (dmemManual)
            bus.dmem_done = bus.instr_valid || bus.imem_req || (cyc == lastHs + 4);
         else
            bus.dmem_done = ($urandom_range(0, 3) == 0);
         start = startPulse || (randStart && ($urandom_range(0, 7) == 0));
      end
   end

   // Reference model: tracks what the sequencer owes (a fetch, an issue, a
   // memory wait or a MAC delay) and advances it from the sampled inputs.
   initial begin
      logic [3:0] op;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            mReq = 0; mValid = 0; mHalted = 0; mErr = 0; mWait = 0; mHold = 0;
            mPc = PCW'(SPC); mCount = '0; mInstr = '0;
         end else if (!mReq && !mValid && !mWait && mHold == 0) begin
            if (start) begin
               mPc = PCW'(SPC); mCount = '0; mHalted = 0; mErr = 0; mReq = 1;
            end
         end else if (mReq) begin
            if (bus.imem_ack) begin
               mReq = 0;
               mInstr = bus.imem_data;
               op = mInstr[15:12];
               if (op == 4'hB)        mHalted = 1;
               else if (!defMask[op]) mErr = 1;
               else                   mValid = 1;
            end
         end else if (mValid) begin
            if (bus.instr_ready) begin
               mValid = 0;
               mPc = mPc + 1'b1;
               if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
               op = mInstr[15:12];
               if (op == 4'hE || op == 4'hF)  mWait = 1;
               else if (op == 4'h4 && MACC > 1) mHold = MACC - 1;
               else                           mReq = 1;
            end
         end else if (mWait) begin
            if (bus.dmem_done) begin
               mWait = 0; mReq = 1;
            end
         end else begin
            mHold = mHold - 1;
            if (mHold == 0) mReq = 1;
         end
      end
   end

   // Per-cycle comparison of every DUT output against the model.
   initial begin
      bit prevReq;
      int shown;
      prevReq = 0; shown = 0;
      forever begin
         @(negedge clk);
         if (checkEn) begin
            tests++;
            if ({bus.imem_req, bus.instr_valid, halted, error} !== {mReq, mValid, mHalted, mErr} ||
                bus.imem_addr !== mPc || pc !== mPc || bus.instr !== mInstr ||
                instr_count !== mCount) begin
               fails++;
               if (shown < 20) begin
                  shown++;
                  $display("FAIL model cyc=%0d got req=%0b vld=%0b hlt=%0b err=%0b pc=%0h addr=%0h instr=%h cnt=%0d, expected req=%0b vld=%0b hlt=%0b err=%0b pc=%0h instr=%h cnt=%0d",
                           cyc, bus.imem_req, bus.instr_valid, halted, error, pc, bus.imem_addr,
                           bus.instr, instr_count, mReq, mValid, mHalted, mErr, mPc, mInstr, mCount);
               end
            end
            if (bus.instr_valid && bus.instr_ready) begin
               issues++;
               lastHs = cyc;
            end
            if (bus.imem_req && !prevReq) lastReqRise = cyc;
            prevReq = bus.imem_req;
         end
      end
   end

   initial begin
      int i0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 reset_n = 1'b1;
      checkEn = 1;
      @(negedge clk);
      check("reset_pc", 32'(pc), SPC);
      check("reset_req", 32'(bus.imem_req), 0);
      check("reset_valid", 32'(bus.instr_valid), 0);
      check("reset_flags", 32'({halted, error}), 0);
      check("reset_instr", 32'(bus.instr), 0);
      check("reset_count", 32'(instr_count), 0);
      check("model_reset_pc", 32'(mPc), SPC);

      // ADD, MUL, HALT with 1-cycle ack and ready always accepted
      mem[2] = 16'h1234; mem[3] = 16'h2ABC; mem[4] = 16'hB000;
      ackRand = 0; ackDelay = 1; rdyRand = 0; rdyDelay = 0;
      i0 = issues;
      pulseStart();
      waitDone(100, "s1");
      repeat (5) @(negedge clk);
      check("s1_issues", 32'(issues - i0), 2);
      check("s1_pc", 32'(pc), 4);
      check("s1_count", 32'(instr_count), 2);
      check("s1_halted", 32'({halted, error}), 32'h2);
      check("s1_req_idle", 32'(bus.imem_req), 0);
      check("s1_instr", 32'(bus.instr), 32'hB000);
      check("model_s1_pc", 32'(mPc), 4);

      // slow memory and slow decode
      mem[2] = 16'h9001; mem[3] = 16'h3005; mem[4] = 16'h0000; mem[5] = 16'hB111;
      ackDelay = 5; rdyDelay = 3;
      i0 = issues;
      pulseStart();
      waitDone(200, "s2");
      check("s2_issues", 32'(issues - i0), 3);
      check("s2_pc", 32'(pc), 5);
      check("s2_count", 32'(instr_count), 3);

      // LD with early dmem_done pulses, real completion 4 cycles after issue
      mem[2] = 16'hE123; mem[3] = 16'hB000;
      ackDelay = 1; rdyDelay = 0; dmemManual = 1;
      i0 = issues;
      pulseStart();
      waitDone(100, "s3");
      check("s3_issues", 32'(issues - i0), 1);
      check("s3_ld_to_fetch", 32'(lastReqRise - lastHs), 5);
      check("s3_pc", 32'(pc), 3);
      dmemManual = 0;

      // MAC occupancy
      mem[2] = 16'h4ABC; mem[3] = 16'hB000;
      pulseStart();
      waitDone(100, "s4");
      check("s4_mac_to_fetch", 32'(lastReqRise - lastHs), MACC);
      check("s4_count", 32'(instr_count), 1);

      // undefined opcode at pc 3, then restart
      mem[2] = 16'h0000; mem[3] = 16'h7123;
      ackRand = 1; ackMax = 2; rdyRand = 1; rdyMax = 2;
      pulseStart();
      waitDone(100, "s5");
      @(negedge clk);
      check("s5_flags", 32'({halted, error}), 32'h1);
      check("s5_pc", 32'(pc), 3);
      check("s5_valid", 32'(bus.instr_valid), 0);
      check("s5_instr", 32'(bus.instr), 32'h7123);
      pulseStart();
      check("s5_restart_pc", 32'(pc), SPC);
      check("s5_restart_err", 32'(error), 0);
      check("s5_restart_req", 32'(bus.imem_req), 1);
      waitDone(100, "s5b");

      // PC wrap: NOPs from 2 through 15 and 0, HALT at 1
      for (int i = 0; i < 16; i++) mem[i] = 16'(i);
      mem[1] = 16'hB001;
      i0 = issues;
      pulseStart();
      waitDone(500, "s6");
      check("s6_issues", 32'(issues - i0), 15);
      check("s6_pc", 32'(pc), 1);
      check("s6_count", 32'(instr_count), 15);

      // asynchronous reset in the middle of a fetch
      ackHold = 1;
      pulseStart();
      check("s6_fetching", 32'(bus.imem_req), 1);
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      check("arst_req", 32'(bus.imem_req), 0);
      check("arst_pc", 32'(pc), SPC);
      check("arst_instr", 32'(bus.instr), 0);
      check("arst_flags", 32'({halted, error, bus.instr_valid}), 0);
      @(posedge clk);
      #3 reset_n = 1'b1;
      ackHold = 0;
      repeat (2) @(negedge clk);
      check("arst_idle", 32'(bus.imem_req), 0);

      // randomized programs, timing and stray start/ack/dmem_done
      ackMax = 3; rdyMax = 3; ackNoise = 1; randStart = 1;
      for (int b = 0; b < 6; b++) begin
         randomizeMem();
         repeat (500) @(negedge clk);
      end
      randStart = 0;
      checkEn = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
